// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard-source and pipeline-control bundle between the core
// and the hazard controller.
//   slave  : the controller side (hazard_ctrl) - samples hazard sources,
//            drives per-stage stall/flush and the sticky CGRA watchdog flag.
//   master : the core side - drives hazard sources, consumes stall/flush.
// Signals:
//   axi_stall_i            bus transaction pending
//   ex_memread_i, ex_rd_i  load in EX and its destination register
//   id_rs1_i, id_rs2_i     source registers of the D instruction
//   id_use_rs1_i/rs2_i     D instruction really reads rs1 / rs2
//   ex_redirect_i          taken branch/jump resolved in EX
//   ex_mc_start_i          CGRA operation issued from EX
//   mc_done_i              CGRA result valid (pulse)
//   mc_to_clr_i            clears mc_timeout_o
//   stallF..stallM         hold stage register
//   flushD..flushW         load bubble into stage register
//   mc_timeout_o           sticky CGRA watchdog error
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic              axi_stall_i;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_rd_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic              ex_redirect_i;
  logic              ex_mc_start_i;
  logic              mc_done_i;
  logic              mc_to_clr_i;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              flushW;
  logic              mc_timeout_o;

  modport slave (
    input  axi_stall_i, ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i,
           id_use_rs1_i, id_use_rs2_i, ex_redirect_i, ex_mc_start_i,
           mc_done_i, mc_to_clr_i,
    output stallF, stallD, stallE, stallM,
           flushD, flushE, flushM, flushW, mc_timeout_o
  );

  modport master (
    output axi_stall_i, ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i,
           id_use_rs1_i, id_use_rs2_i, ex_redirect_i, ex_mc_start_i,
           mc_done_i, mc_to_clr_i,
    input  stallF, stallD, stallE, stallM,
           flushD, flushE, flushM, flushW, mc_timeout_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-stage stall/flush generation for the 5-stage core with the
// CGRA offload path. Sources, highest priority first: AXI wait, CGRA wait
// (MC state), EX redirect, CGRA issue, load-use (hit or LU state).
// Stall/flush outputs are combinational; state, counters and the watchdog
// flag are registered. Reset is synchronous, active-low (arestn).
// Ports:
//   clk     core clock
//   arestn  synchronous active-low reset
//   hz      hazard_ctrl_if.slave bundle (hazard sources in, controls out)
// Build option:
//   HAZARD_MC_WDOG_EN  compiles in the CGRA watchdog counter and the sticky
//                      mc_timeout_o flag; otherwise MC waits forever and
//                      mc_timeout_o is tied low.
module hazard_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LU_CYCLES  = 1,
  parameter int unsigned TO_W       = 8,
  parameter int unsigned MC_TIMEOUT = 200
) (
  input logic          clk,
  input logic          arestn,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE, LU, MC} state_e;

  // LU is entered after the first bubble, so it counts the remaining ones.
  localparam logic [1:0] LU_INIT = (LU_CYCLES > 1) ? 2'(LU_CYCLES - 2) : 2'd0;

  state_e      state, nextState;
  logic [1:0]  luCnt, nextLuCnt;
  logic        stF, stD, stE, stM, flD, flE, flM, flW;
  logic        wdClr, wdInc, wdHit, toSet;
  logic        luHit;
  logic [REG_AW-1:0] exRd, idRs1, idRs2;

  assign exRd  = hz.ex_rd_i;
  assign idRs1 = hz.id_rs1_i;
  assign idRs2 = hz.id_rs2_i;

  assign luHit = hz.ex_memread_i && (exRd != '0) &&
                 ((hz.id_use_rs1_i && (exRd == idRs1)) ||
                  (hz.id_use_rs2_i && (exRd == idRs2)));

  always_comb begin
    stF       = 1'b0;
    stD       = 1'b0;
    stE       = 1'b0;
    stM       = 1'b0;
    flD       = 1'b0;
    flE       = 1'b0;
    flM       = 1'b0;
    flW       = 1'b0;
    nextState = state;
    nextLuCnt = luCnt;
    wdClr     = 1'b0;
    wdInc     = 1'b0;
    toSet     = 1'b0;
    if (!arestn) begin
      // outputs held low during reset; registers reset in always_ff
    end else if (hz.axi_stall_i) begin
      // whole pipeline frozen; defaults keep state and counters unchanged
      stF = 1'b1;
      stD = 1'b1;
      stE = 1'b1;
      stM = 1'b1;
      flW = 1'b1;
    end else begin
      case (state)
        MC: begin
          if (hz.mc_done_i) begin
            nextState = IDLE;
          end else if (wdHit) begin
            toSet     = 1'b1;
            nextState = IDLE;
          end else begin
            stF   = 1'b1;
            stD   = 1'b1;
            stE   = 1'b1;
            flM   = 1'b1;
            wdInc = 1'b1;
          end
        end
        default: begin
          // IDLE and LU share the redirect / issue priority chain
          if (hz.ex_redirect_i) begin
            flD       = 1'b1;
            flE       = 1'b1;
            nextState = IDLE;
          end else if (hz.ex_mc_start_i) begin
            stF       = 1'b1;
            stD       = 1'b1;
            stE       = 1'b1;
            flM       = 1'b1;
            wdClr     = 1'b1;
            nextState = MC;
          end else if (state == LU) begin
            stF = 1'b1;
            stD = 1'b1;
            flE = 1'b1;
            if (luCnt == 2'd0) nextState = IDLE;
            else               nextLuCnt = luCnt - 2'd1;
          end else if (luHit) begin
            stF = 1'b1;
            stD = 1'b1;
            flE = 1'b1;
            if (LU_CYCLES > 1) begin
              nextState = LU;
              nextLuCnt = LU_INIT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arestn) begin
      state <= IDLE;
      luCnt <= '0;
    end else begin
      state <= nextState;
      luCnt <= nextLuCnt;
    end
  end

`ifdef HAZARD_MC_WDOG_EN
  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(MC_TIMEOUT - 1);

  logic [TO_W-1:0] wdCnt;
  logic            toFlag;

  // wdCnt holds the number of completed MC wait cycles, so the compare
  // fires on the MC_TIMEOUT-th MC cycle.
  assign wdHit = (wdCnt == WD_LIMIT);

  always_ff @(posedge clk) begin
    if (!arestn) begin
      wdCnt  <= '0;
      toFlag <= 1'b0;
    end else begin
      if (wdClr)      wdCnt <= '0;
      else if (wdInc) wdCnt <= wdCnt + TO_W'(1);
      if (hz.mc_to_clr_i) toFlag <= 1'b0;
      else if (toSet)     toFlag <= 1'b1;
    end
  end

  assign hz.mc_timeout_o = toFlag & arestn;
`else
  logic unusedWd;

  assign wdHit           = 1'b0;
  assign hz.mc_timeout_o = 1'b0;
  assign unusedWd        = ^{wdClr, wdInc, toSet, hz.mc_to_clr_i};
`endif

  assign hz.stallF = stF;
  assign hz.stallD = stD;
  assign hz.stallE = stE;
  assign hz.stallM = stM;
  assign hz.flushD = flD;
  assign hz.flushE = flE;
  assign hz.flushM = flM;
  assign hz.flushW = flW;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RISC-V core with the CGRA offload path. It generates per-stage stall and flush controls for F/D/E/M/W from four sources: AXI bus wait, load-use dependency, EX-stage control redirect, and multi-cycle CGRA operations. Load-use bubbles and CGRA waits are sequenced by a small FSM, with an optional watchdog on the CGRA handshake. It replaces the pure AXI-stall passthrough in the core top level.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- LU_CYCLES, 1, load-use bubbles inserted per hazard (1..4).
- TO_W, 8, CGRA watchdog counter width.
- MC_TIMEOUT, 200, CGRA watchdog limit in counted cycles (2..2^TO_W-1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- arestn  in  1  reset, synchronous, active-low.
- axi_stall_i  in  1  bus transaction pending; freezes the pipeline.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rd_i  in  REG_AW  destination register of the EX instruction.
- id_rs1_i, id_rs2_i  in  REG_AW  source registers of the D instruction.
- id_use_rs1_i, id_use_rs2_i  in  1  D instruction actually reads rs1 / rs2.
- ex_redirect_i  in  1  taken branch or jump resolved in EX.
- ex_mc_start_i  in  1  CGRA operation issued from EX.
- mc_done_i  in  1  CGRA result valid (single-cycle pulse).
- mc_to_clr_i  in  1  clears the sticky watchdog flag.
- stallF, stallD, stallE, stallM  out  1  hold the stage register.
- flushD, flushE, flushM, flushW  out  1  load a bubble into the stage register.
- mc_timeout_o  out  1  sticky CGRA watchdog error.

## Operation
- FSM states: IDLE, LU (load-use bubbles), MC (CGRA wait).
- lu_hit = ex_memread_i & ex_rd_i≠0 & ((id_use_rs1_i & ex_rd_i==id_rs1_i) | (id_use_rs2_i & ex_rd_i==id_rs2_i)).
- Priority, highest first: axi_stall_i, MC state, ex_redirect_i, ex_mc_start_i, lu_hit / LU state.
- axi_stall_i=1, in any state: stallF/D/E/M=1 and flushW=1. All other flushes are 0. FSM, counters and the watchdog are frozen.
- IDLE, ex_redirect_i: flushD=flushE=1. No stall. ex_mc_start_i and lu_hit are ignored that cycle.
- IDLE, ex_mc_start_i: stallF/D/E=1 and flushM=1. Next state is MC, with the watchdog cleared to 0.
- IDLE, lu_hit: stallF=stallD=1 and flushE=1. If LU_CYCLES>1, the next state is LU with lu_cnt=LU_CYCLES-2.
- LU: stallF=stallD=1 and flushE=1 each cycle. lu_cnt decrements; at lu_cnt==0 the next state is IDLE. ex_redirect_i in LU drops the stall, drives flushD=flushE=1, and goes to IDLE.
- MC: stallF/D/E=1 and flushM=1 while waiting.
  - mc_done_i=1: all stalls and flushes are 0 that cycle, so EX advances with the result. Next state is IDLE.
  - ex_redirect_i and ex_mc_start_i are ignored in MC.
- Watchdog (macro-enabled): increments each non-frozen MC cycle without mc_done_i. When it reaches MC_TIMEOUT-1, mc_timeout_o is set, the stall is released as if mc_done_i, and the next state is IDLE.
  - mc_done_i in the same cycle as the limit counts as done; no error is flagged.
- mc_timeout_o stays set until mc_to_clr_i. Clear has priority over a same-cycle set.
- mc_done_i outside MC is ignored.

## Timing
- Stall and flush outputs are combinational from state and inputs: zero-cycle response to hazards.
- State, lu_cnt, watchdog and mc_timeout_o are registered; they update on the clk edge after the triggering cycle.
- While arestn=0: all outputs 0, state IDLE, counters 0, mc_timeout_o=0. Reset asserted mid-LU or mid-MC aborts the sequence at the next edge.
- Load-use cost is exactly LU_CYCLES stall cycles, each with a bubble into E.
- CGRA cost is N+1 cycles for mc_done_i N cycles after issue, excluding AXI-frozen cycles.
- AXI freezing in LU or MC extends that state by the frozen cycles; lu_cnt and the watchdog do not advance.

## Configuration
- HAZARD_MC_WDOG_EN defined: the watchdog counter and mc_timeout_o logic are compiled in as described.
- HAZARD_MC_WDOG_EN undefined:
  - No counter is built.
  - MC waits indefinitely for mc_done_i.
  - mc_timeout_o is tied 0 and mc_to_clr_i is unused.

## Test plan
- Load-use, LU_CYCLES=2: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, id_use_rs2_i=1 -> stallF/D=1 and flushE=1 for exactly 2 cycles, then all 0. The same stimulus with ex_rd_i=0, or with id_use_rs2_i=0, gives no stall.
- Redirect with coincident lu_hit -> flushD=flushE=1, stallF=stallD=0, FSM stays IDLE.
- CGRA: ex_mc_start_i pulse, mc_done_i 6 cycles later -> stallF/D/E=1 and flushM=1 for 6 cycles, all 0 in the done cycle, IDLE next cycle.
- AXI freeze: axi_stall_i high for 3 cycles mid-MC -> stallF/D/E/M=1 and flushW=1 for those cycles. Completion is delayed by exactly 3 cycles.
- Watchdog (macro on, MC_TIMEOUT=10): no mc_done_i -> stall released and mc_timeout_o=1 on the 10th MC cycle. mc_to_clr_i clears it. With the macro off, the stall persists past 1000 cycles.
- arestn low for 1 cycle while in MC -> all outputs 0, IDLE and mc_timeout_o=0 after the edge.
